// File: rtl/xif_offload_ctrl_if.sv
// Decode-side and CORE-V-X-IF issue-side signals of xif_offload_ctrl, grouped for one port.
// Directions in the slave modport are as seen by the controller.
interface xif_offload_ctrl_if #(
  parameter int IDW = 3,
  parameter int OW  = 3
);
  logic           flush_i;
  logic           instr_valid_i;
  logic [31:0]    instr_i;
  logic           instr_ready_o;
  logic           x_issue_valid_o;
  logic [31:0]    x_issue_instr_o;
  logic [IDW-1:0] x_issue_id_o;
  logic           x_issue_ready_i;
  logic           x_issue_accept_i;
  logic           x_result_valid_i;
  logic           offload_accepted_o;
  logic           offload_rejected_o;
  logic [OW-1:0]  outstanding_o;
  logic           full_o;
  logic           protocol_err_o;
  logic           timeout_o;

  modport slave (
    input  flush_i, instr_valid_i, instr_i, x_issue_ready_i, x_issue_accept_i, x_result_valid_i,
    output instr_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_id_o,
           offload_accepted_o, offload_rejected_o, outstanding_o, full_o, protocol_err_o, timeout_o
  );

  modport master (
    output flush_i, instr_valid_i, instr_i, x_issue_ready_i, x_issue_accept_i, x_result_valid_i,
    input  instr_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_id_o,
           offload_accepted_o, offload_rejected_o, outstanding_o, full_o, protocol_err_o, timeout_o
  );
endinterface

// File: rtl/xif_offload_ctrl.sv
// XIF issue sequencer: capture->valid 1 cycle, one offload per 2 cycles, capture stalls while full_o.
// XIF_OFFLOAD_TIMEOUT_EN adds an issue-handshake watchdog that rejects after TIMEOUT_CYCLES stalled cycles.
module xif_offload_ctrl #(
  parameter int NR_ENTRIES      = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic               clk_i,
  input logic               rst_i,
  xif_offload_ctrl_if.slave bus
);
  localparam int IDW = $clog2(NR_ENTRIES);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  generate
    if (NR_ENTRIES < 2 || (NR_ENTRIES & (NR_ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("NR_ENTRIES must be a power of 2 and at least 2");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NR_ENTRIES) begin : g_bad_credits
      $error("MAX_OUTSTANDING must be in 1..NR_ENTRIES");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t         r_state;
  logic [31:0]    r_instr;
  logic [IDW-1:0] r_issue_id;
  logic [IDW-1:0] r_id_cnt;
  logic [OW-1:0]  r_outstanding;
  logic           r_proto_err;

  logic w_full;
  logic w_capture;
  logic w_hs;
  logic w_acc;
  logic w_rej;
  logic w_tmo_hit;
  logic w_tmo_pulse;

  assign w_full    = (r_outstanding == OW'(MAX_OUTSTANDING));
  assign w_capture = !rst_i && (r_state == IDLE) && bus.instr_valid_i && !w_full && !bus.flush_i;
  // Gated by reset so a handshake seen during reset never produces a pulse.
  assign w_hs      = !rst_i && (r_state == REQ) && bus.x_issue_ready_i;
  assign w_acc     = w_hs && bus.x_issue_accept_i;
  assign w_rej     = w_hs && !bus.x_issue_accept_i;

`ifdef XIF_OFFLOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout;

  // Hit on the last stalled REQ cycle; the pulse and the drop of valid follow one cycle later.
  assign w_tmo_hit = !rst_i && (r_state == REQ) && !bus.x_issue_ready_i && !bus.flush_i &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_hit;
      if ((r_state == REQ) && !w_hs && !bus.flush_i && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  assign w_tmo_pulse = r_timeout;
`else
  assign w_tmo_hit   = 1'b0;
  assign w_tmo_pulse = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_issue_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_instr    <= bus.instr_i;
            r_issue_id <= r_id_cnt;
            r_state    <= REQ;
          end
        end
        REQ: begin
          // A completing handshake takes priority over a simultaneous flush.
          if (w_hs || bus.flush_i || w_tmo_hit) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_cnt      <= '0;
      r_outstanding <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_id_cnt <= (r_id_cnt == IDW'(NR_ENTRIES - 1)) ? '0 : r_id_cnt + IDW'(1);
      end
      case ({w_acc, bus.x_result_valid_i})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01: begin
          if (r_outstanding == '0) begin
            r_proto_err <= 1'b1;
          end else begin
            r_outstanding <= r_outstanding - OW'(1);
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign bus.instr_ready_o      = w_capture;
  assign bus.x_issue_valid_o    = (r_state == REQ);
  assign bus.x_issue_instr_o    = r_instr;
  assign bus.x_issue_id_o       = r_issue_id;
  assign bus.offload_accepted_o = w_acc;
  assign bus.offload_rejected_o = w_rej || w_tmo_pulse;
  assign bus.outstanding_o      = r_outstanding;
  assign bus.full_o             = w_full;
  assign bus.protocol_err_o     = r_proto_err;
  assign bus.timeout_o          = w_tmo_pulse;
endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Bench for xif_offload_ctrl: per-cycle vector table, hand-written corner sequences, and an
// issue scoreboard that checks every completed handshake carries the captured instruction and id.
module tb_xif_offload_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  xif_offload_ctrl_if #(.IDW(3), .OW(3)) bus ();

  xif_offload_ctrl #(
    .NR_ENTRIES     (8),
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    int          flush;
    int          valid;
    logic [31:0] instr;
    int          ready;
    int          acc;
    int          res;
    int          e_rdy;
    int          e_vld;
    int          e_acc;
    int          e_rej;
    int          e_out;
    int          e_full;
    int          e_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  id;
  } sb_t;

  localparam int NV = 30;

  vec_t       vec [NV];
  sb_t        sbq [$];
  logic [2:0] m_id;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_cmp    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: scoreboard had no pending entry", name);
  endtask

  function automatic vec_t v(input int flush, input int valid, input logic [31:0] instr,
                             input int ready, input int acc, input int res,
                             input int e_rdy, input int e_vld, input int e_acc, input int e_rej,
                             input int e_out, input int e_full, input int e_err);
    vec_t r;
    r.flush = flush; r.valid = valid; r.instr = instr; r.ready = ready; r.acc = acc; r.res = res;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_acc = e_acc; r.e_rej = e_rej;
    r.e_out = e_out; r.e_full = e_full; r.e_err = e_err;
    return r;
  endfunction

  task automatic check_outs(input string tag, input int rdy, input int vld, input int acc,
                            input int rej, input int out, input int full, input int err);
    chk({tag, "_rdy"},  32'(bus.instr_ready_o),      rdy);
    chk({tag, "_vld"},  32'(bus.x_issue_valid_o),    vld);
    chk({tag, "_acc"},  32'(bus.offload_accepted_o), acc);
    chk({tag, "_rej"},  32'(bus.offload_rejected_o), rej);
    chk({tag, "_out"},  32'(bus.outstanding_o),      out);
    chk({tag, "_full"}, 32'(bus.full_o),             full);
    chk({tag, "_err"},  32'(bus.protocol_err_o),     err);
  endtask

  task automatic idle_inputs();
    bus.flush_i          = 1'b0;
    bus.instr_valid_i    = 1'b0;
    bus.x_issue_ready_i  = 1'b0;
    bus.x_issue_accept_i = 1'b0;
    bus.x_result_valid_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on capture, pop and compare on handshake, discard on flush/timeout.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      sbq.delete();
      m_id = 3'd0;
    end else begin
      if (bus.x_issue_valid_o && bus.x_issue_ready_i) begin
        if (sbq.size() == 0) begin
          fail("sb_handshake");
        end else begin
          e = sbq.pop_front();
          n_cmp++;
          chk("sb_instr", bus.x_issue_instr_o, e.instr);
          chk("sb_id", 32'(bus.x_issue_id_o), 32'(e.id));
          if (bus.x_issue_accept_i) m_id = m_id + 3'd1;
        end
      end else if ((bus.x_issue_valid_o && bus.flush_i) || bus.timeout_o) begin
        if (sbq.size() == 0) fail("sb_discard");
        else void'(sbq.pop_front());
      end
      if (bus.instr_ready_o) sbq.push_back('{instr: bus.instr_i, id: m_id});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        flush valid instr          rdy acc res  e_rdy vld acc rej out full err
    vec[0]  = v(0, 1, 32'h0000_500B, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vec[1]  = v(0, 0, 32'h0000_500B, 1, 1, 0,   0, 1, 1, 0, 0, 0, 0);
    vec[2]  = v(0, 0, 32'h0000_0000, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    vec[3]  = v(0, 1, 32'h0000_00A1, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0);
    vec[4]  = v(0, 0, 32'h0000_00A1, 1, 0, 0,   0, 1, 0, 1, 1, 0, 0);
    vec[5]  = v(0, 1, 32'h0000_00A2, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0);
    vec[6]  = v(0, 0, 32'h0000_00A2, 1, 1, 0,   0, 1, 1, 0, 1, 0, 0);
    vec[7]  = v(0, 1, 32'h0000_00A3, 0, 0, 0,   1, 0, 0, 0, 2, 0, 0);
    vec[8]  = v(0, 0, 32'h0000_00A3, 1, 1, 0,   0, 1, 1, 0, 2, 0, 0);
    vec[9]  = v(0, 1, 32'h0000_00A4, 0, 0, 0,   1, 0, 0, 0, 3, 0, 0);
    vec[10] = v(0, 0, 32'h0000_00A4, 1, 1, 0,   0, 1, 1, 0, 3, 0, 0);
    vec[11] = v(0, 1, 32'h0000_00A5, 0, 0, 0,   0, 0, 0, 0, 4, 1, 0);
    vec[12] = v(0, 1, 32'h0000_00A5, 0, 0, 0,   0, 0, 0, 0, 4, 1, 0);
    vec[13] = v(0, 1, 32'h0000_00A5, 0, 0, 1,   0, 0, 0, 0, 4, 1, 0);
    vec[14] = v(0, 1, 32'h0000_00A5, 0, 0, 0,   1, 0, 0, 0, 3, 0, 0);
    vec[15] = v(0, 0, 32'h0000_00A5, 0, 0, 1,   0, 1, 0, 0, 3, 0, 0);
    vec[16] = v(0, 0, 32'h0000_00A5, 1, 1, 1,   0, 1, 1, 0, 2, 0, 0);
    vec[17] = v(0, 0, 32'h0000_0000, 0, 0, 0,   0, 0, 0, 0, 2, 0, 0);
    vec[18] = v(0, 0, 32'h0000_0000, 0, 0, 1,   0, 0, 0, 0, 2, 0, 0);
    vec[19] = v(0, 0, 32'h0000_0000, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    vec[20] = v(0, 0, 32'h0000_0000, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    vec[21] = v(0, 0, 32'h0000_0000, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec[22] = v(1, 1, 32'h0000_00B0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec[23] = v(0, 1, 32'h0000_00B0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    vec[24] = v(0, 0, 32'h0000_00B0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    vec[25] = v(1, 0, 32'h0000_00B0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    vec[26] = v(0, 0, 32'h0000_00B0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vec[27] = v(0, 1, 32'h0000_00B1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    vec[28] = v(1, 0, 32'h0000_00B1, 1, 1, 0,   0, 1, 1, 0, 0, 0, 1);
    vec[29] = v(0, 0, 32'h0000_0000, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1);

    // Reset with every input active: all outputs must stay low.
    rst                  = 1'b1;
    bus.flush_i          = 1'b0;
    bus.instr_valid_i    = 1'b1;
    bus.instr_i          = 32'hDEAD_BEEF;
    bus.x_issue_ready_i  = 1'b1;
    bus.x_issue_accept_i = 1'b1;
    bus.x_result_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset_instr", bus.x_issue_instr_o, 32'h0);
    chk("reset_id", 32'(bus.x_issue_id_o), 32'h0);
    chk("reset_tmo", 32'(bus.timeout_o), 32'h0);
    step();
    rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < NV; i++) begin
      bus.flush_i          = vec[i].flush[0];
      bus.instr_valid_i    = vec[i].valid[0];
      bus.instr_i          = vec[i].instr;
      bus.x_issue_ready_i  = vec[i].ready[0];
      bus.x_issue_accept_i = vec[i].acc[0];
      bus.x_result_valid_i = vec[i].res[0];
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vec[i].e_rdy, vec[i].e_vld, vec[i].e_acc, vec[i].e_rej,
                 vec[i].e_out, vec[i].e_full, vec[i].e_err);
      step();
    end
    idle_inputs();

    // Reset while an issue is pending: no pulse, valid gone after the edge, sticky error cleared.
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h0000_00D0;
    @(negedge clk);
    chk("rstreq_cap", 32'(bus.instr_ready_o), 32'h1);
    step();
    bus.instr_valid_i    = 1'b0;
    bus.x_issue_ready_i  = 1'b1;
    bus.x_issue_accept_i = 1'b1;
    rst                  = 1'b1;
    @(negedge clk);
    chk("rstreq_vld_before", 32'(bus.x_issue_valid_o), 32'h1);
    chk("rstreq_acc", 32'(bus.offload_accepted_o), 32'h0);
    chk("rstreq_rej", 32'(bus.offload_rejected_o), 32'h0);
    step();
    @(negedge clk);
    check_outs("rstreq_after", 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    idle_inputs();

    // Nine accepted offloads, each returned: ids run 0..7 then wrap to 0.
    for (int i = 0; i < 9; i++) begin
      bus.x_result_valid_i = 1'b0;
      bus.instr_valid_i    = 1'b1;
      bus.instr_i          = 32'hC000_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("wrap%0d_rdy", i), 32'(bus.instr_ready_o), 32'h1);
      step();
      bus.instr_valid_i    = 1'b0;
      bus.x_issue_ready_i  = 1'b1;
      bus.x_issue_accept_i = 1'b1;
      @(negedge clk);
      chk($sformatf("wrap%0d_id", i), 32'(bus.x_issue_id_o), 32'(i % 8));
      chk($sformatf("wrap%0d_acc", i), 32'(bus.offload_accepted_o), 32'h1);
      step();
      bus.x_issue_ready_i  = 1'b0;
      bus.x_issue_accept_i = 1'b0;
      bus.x_result_valid_i = 1'b1;
      @(negedge clk);
      step();
    end
    bus.x_result_valid_i = 1'b0;
    @(negedge clk);
    chk("wrap_out", 32'(bus.outstanding_o), 32'h0);
    chk("wrap_err", 32'(bus.protocol_err_o), 32'h0);
    step();

    // Issue stalled with ready low for 64 REQ cycles.
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h0000_00E0;
    @(negedge clk);
    chk("tmo_cap", 32'(bus.instr_ready_o), 32'h1);
    step();
    bus.instr_valid_i = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_wait%0d_vld", k), 32'(bus.x_issue_valid_o), 32'h1);
      chk($sformatf("tmo_wait%0d_tmo", k), 32'(bus.timeout_o), 32'h0);
      step();
    end
    @(negedge clk);
`ifdef XIF_OFFLOAD_TIMEOUT_EN
    chk("tmo_vld", 32'(bus.x_issue_valid_o), 32'h0);
    chk("tmo_pulse", 32'(bus.timeout_o), 32'h1);
    chk("tmo_rej", 32'(bus.offload_rejected_o), 32'h1);
    chk("tmo_acc", 32'(bus.offload_accepted_o), 32'h0);
    step();
    @(negedge clk);
    chk("tmo_pulse_end", 32'(bus.timeout_o), 32'h0);
    chk("tmo_rej_end", 32'(bus.offload_rejected_o), 32'h0);
    chk("tmo_rdy_again", 32'(bus.full_o), 32'h0);
    step();
    chk("sb_cmp_count", 32'(n_cmp), 32'd16);
`else
    chk("notmo_vld", 32'(bus.x_issue_valid_o), 32'h1);
    chk("notmo_tmo", 32'(bus.timeout_o), 32'h0);
    chk("notmo_rej", 32'(bus.offload_rejected_o), 32'h0);
    step();
    bus.x_issue_ready_i = 1'b1;
    @(negedge clk);
    chk("notmo_final_rej", 32'(bus.offload_rejected_o), 32'h1);
    step();
    bus.x_issue_ready_i = 1'b0;
    @(negedge clk);
    chk("notmo_idle_vld", 32'(bus.x_issue_valid_o), 32'h0);
    chk("sb_cmp_count", 32'(n_cmp), 32'd17);
`endif
    chk("sb_drain", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
